uart_string_sender: RTL
=======================

// Module: uart_string_sender
// PURPOSE
//  Buffers a short ASCII string and transmits it byte-by-byte over UART by driving
//  the async_transmitter handshake (TxD_start / TxD_data / TxD_busy).
//  Transmit-side counterpart to the receive path and word-detector FSM: reply
//  strings (e.g. "OK", detected word) are loaded here, then sent on request.
//  Optional CR LF terminator appended after the buffered bytes.
// PARAMETERS
//  DEPTH        16  buffer capacity in bytes (power of 2)
//  ADDR_W       4   log2(DEPTH)
//  APPEND_CRLF  1   1: send 8'h0D then 8'h0A after the last buffered byte; 0: no terminator
// PORTS
//  clk       in   1         system clock (MAX10_CLK1_50 domain)
//  rst       in   1         synchronous reset, active-low
//  wr_en     in   1         write wr_data into buffer this cycle
//  wr_data   in   8         byte to append
//  clear     in   1         empty buffer (honoured only in IDLE)
//  send      in   1         start transmitting buffer contents (honoured only in IDLE)
//  tx_busy   in   1         async_transmitter TxD_busy
//  tx_start  out  1         async_transmitter TxD_start, one-cycle pulse
//  tx_data   out  8         async_transmitter TxD_data, registered, stable while sending
//  full      out  1         count == DEPTH
//  count     out  ADDR_W+1  bytes currently buffered
//  busy      out  1         high in every state except IDLE
//  done      out  1         one-cycle pulse when the last byte (incl. terminator) has finished
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state IDLE; count=0; rd/wr ptr=0; tx_start=0; tx_data=8'h00;
//    full=0; busy=0; done=0. Reset mid-transmission aborts at once; tx_start is low the
//    next cycle; the byte already handed to the transmitter is not recalled.
//  - Buffer: circular, wr_ptr/rd_ptr ADDR_W bits, wrap DEPTH-1 -> 0; count ADDR_W+1 bits.
//    Write accepted only when IDLE && !full && !send && !clear; otherwise dropped silently
//    (no count change). A write when full is dropped.
//  - clear in IDLE: count, rd_ptr, wr_ptr -> 0 next cycle. clear outside IDLE is ignored.
//  - Priority in IDLE, same cycle: clear > send > wr_en.
//  - FSM states: IDLE, LOAD, PULSE, ACK, DRAIN, TERM_CR, TERM_LF, FIN.
//    IDLE  : send -> LOAD. If count==0 and APPEND_CRLF==0 -> FIN (done pulse, no bytes sent).
//            If count==0 and APPEND_CRLF==1 -> TERM_CR.
//    LOAD  : tx_data <= buf[rd_ptr]; rd_ptr++; count--; -> PULSE.
//    TERM_CR / TERM_LF: tx_data <= 8'h0D / 8'h0A; -> PULSE.
//    PULSE : when tx_busy==0, assert tx_start for exactly this one cycle; -> ACK.
//            Wait in PULSE while tx_busy==1.
//    ACK   : wait for tx_busy==1; -> DRAIN. If tx_busy is not seen high within 4 cycles,
//            go to DRAIN anyway, so the FSM cannot hang on a transmitter that never raises busy.
//    DRAIN : wait for tx_busy==0, then select the next step:
//            count>0 -> LOAD;
//            count==0 and last byte was a data byte and APPEND_CRLF -> TERM_CR;
//            last byte was CR -> TERM_LF;
//            otherwise -> FIN.
//    FIN   : done=1 for one cycle; -> IDLE. Buffer is empty on return (ptrs equal).
//  - Latency: send at edge N with tx_busy low -> tx_data valid after edge N+1, tx_start high
//    after edge N+2. tx_data never changes between the tx_start pulse and the following DRAIN exit.
//  - Each byte gets exactly one tx_start pulse. Bytes go out in write order.
//  - Writes during busy are dropped; software must wait for done.
// TESTING
//  1 Write "HI" (8'h48, 8'h49), send, APPEND_CRLF=1, transmitter model with 10-cycle busy
//    -> tx_data seq 48,49,0D,0A, 4 tx_start pulses, one done pulse, count==0 after.
//  2 Write 16 bytes then a 17th -> full=1, count==16, 17th dropped; send -> 16 bytes + CR LF
//    in order, wrap exercised on a second fill.
//  3 send with empty buffer: APPEND_CRLF=0 -> done 2 cycles later, no tx_start;
//    APPEND_CRLF=1 -> only 0D,0A sent.
//  4 tx_busy held high at send -> tx_start withheld until busy drops; busy never rising
//    after a pulse -> ACK timeout, next byte still sent once.
//  5 rst low mid-DRAIN of byte 2 of 5 -> next cycle tx_start=0, busy=0, count=0;
//    subsequent write+send works normally.
//  6 clear+send+wr_en in same IDLE cycle -> buffer emptied, nothing sent, busy stays 0.

Source files
------------

// File: rtl/uart_string_sender.sv
// Buffers a short ASCII string and sends it one byte at a time through the
// async_transmitter start/busy handshake, optionally followed by CR LF.
module uart_string_sender #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [7:0]        wr_data_i,
  input  logic              clear_i,
  input  logic              send_i,
  input  logic              tx_busy_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    IDLE, LOAD, PULSE, ACK, DRAIN, TERM_CR, TERM_LF, FIN
  } state_e;

  typedef enum logic [1:0] {
    LAST_DATA, LAST_CR, LAST_LF
  } last_e;

  localparam logic [ADDR_W:0] FULL_COUNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0]      ACK_TIMEOUT = 2'd3;

  state_e            state_q, state_d;
  last_e             last_q, last_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              done_q, done_d;
  logic [1:0]        ack_cnt_q, ack_cnt_d;
  logic [7:0]        mem_q [DEPTH];
  logic              full;
  logic              wr_accept;

  assign full = (count_q == FULL_COUNT);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    ack_cnt_d  = ack_cnt_q;
    wr_accept  = 1'b0;

    unique case (state_q)
      // clear beats send beats write; all three are only honoured here
      IDLE: begin
        if (clear_i) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else if (send_i) begin
          if (count_q != '0) begin
            state_d = LOAD;
          end else if (APPEND_CRLF) begin
            state_d = TERM_CR;
          end else begin
            state_d = FIN;
          end
        end else if (wr_en_i && !full) begin
          wr_accept = 1'b1;
          wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
          count_d   = count_q + (ADDR_W+1)'(1);
        end
      end
      LOAD: begin
        tx_data_d = mem_q[rd_ptr_q];
        rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
        count_d   = count_q - (ADDR_W+1)'(1);
        last_d    = LAST_DATA;
        state_d   = PULSE;
      end
      TERM_CR: begin
        tx_data_d = 8'h0D;
        last_d    = LAST_CR;
        state_d   = PULSE;
      end
      TERM_LF: begin
        tx_data_d = 8'h0A;
        last_d    = LAST_LF;
        state_d   = PULSE;
      end
      PULSE: begin
        if (!tx_busy_i) begin
          tx_start_d = 1'b1;
          ack_cnt_d  = '0;
          state_d    = ACK;
        end
      end
      // Bounded wait so a transmitter that never raises busy cannot stall us
      ACK: begin
        if (tx_busy_i || ack_cnt_q == ACK_TIMEOUT) begin
          state_d = DRAIN;
        end else begin
          ack_cnt_d = ack_cnt_q + 2'd1;
        end
      end
      DRAIN: begin
        if (!tx_busy_i) begin
          if (count_q != '0) begin
            state_d = LOAD;
          end else if (last_q == LAST_DATA && APPEND_CRLF) begin
            state_d = TERM_CR;
          end else if (last_q == LAST_CR) begin
            state_d = TERM_LF;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      last_q     <= LAST_DATA;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      ack_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
      ack_cnt_q  <= ack_cnt_d;
    end
  end

  // Storage needs no reset; only the pointers and count define its contents
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign full_o     = full;
  assign count_o    = count_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;

endmodule
